// File: rtl/hvsync_decoder_pkg.sv
// Shared definitions for the VGA sync decoder.
// Holds the nominal 640x480 timing used as the decoder's default mode, the
// counter widths shared by the decoder ports, and the lock FSM state encoding.
package hvsync_decoder_pkg;

    // Nominal horizontal timing (pixel clocks)
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    // Nominal vertical timing (lines)
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 33;

    // Cycles from generator hpos==H_SYNC_START until our hpos reload takes effect
    localparam int DEF_SYNC_LAT    = 2;
    // Consecutive good frames needed before declaring lock
    localparam int DEF_LOCK_FRAMES = 2;

    localparam int POS_W  = 10;  // hpos/vpos/frame_lines/line_cnt width
    localparam int PER_W  = 11;  // per_cnt/line_period width

    typedef enum logic [2:0] {
        ST_SEARCH  = 3'd0,  // waiting for any hsync edge
        ST_H_MEAS  = 3'd1,  // measuring one line period
        ST_V_ALIGN = 3'd2,  // line ok, waiting for a vsync edge to start counting
        ST_V_MEAS  = 3'd3,  // counting lines per frame
        ST_LOCKED  = 3'd4   // timing verified, positions trusted
    } state_e;

endpackage

// File: rtl/hvsync_decoder_sync_edge_detect.sv
// Sync edge detector: registers one sync input and flags its rising edge.
// Ports:
//   clk     in  pixel clock
//   reset   in  asynchronous active-high reset
//   sync_i  in  sync level from the generator
//   rise_o  out high in the cycle where sync_i is 1 and was 0 last cycle
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic rise_o
);

    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            sync_q <= sync_i;
        end
    end

    // Combinational so the rise is acted on in the same cycle it arrives.
    assign rise_o = sync_i & ~sync_q;

endmodule

// File: rtl/hvsync_decoder.sv
// VGA sync decoder: recovers beam position from hsync/vsync, measures the line
// period and frame height, and declares lock when they match the configured mode.
// Ports:
//   clk          in   pixel clock
//   reset        in   asynchronous active-high reset, clears all state
//   hsync_in     in   horizontal sync, active-high
//   vsync_in     in   vertical sync, active-high
//   hpos         out  recovered horizontal position
//   vpos         out  recovered vertical position
//   display_on   out  locked and inside the visible area
//   locked       out  timing verified for LOCK_FRAMES frames
//   sync_err     out  one-cycle pulse on a timing violation while locked
//   line_period  out  last hsync-rise to hsync-rise period (cycles)
//   frame_lines  out  last vsync-rise to vsync-rise line count
module hvsync_decoder
    import hvsync_decoder_pkg::*;
#(
    parameter int H_DISPLAY   = DEF_H_DISPLAY,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_DISPLAY   = DEF_V_DISPLAY,
    parameter int V_BOTTOM    = DEF_V_BOTTOM,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_TOP       = DEF_V_TOP,
    parameter int SYNC_LAT    = DEF_SYNC_LAT,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             display_on,
    output logic             locked,
    output logic             sync_err,
    output logic [PER_W-1:0] line_period,
    output logic [POS_W-1:0] frame_lines
);

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;

    localparam logic [POS_W-1:0] H_LAST    = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST    = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_RELOAD  = POS_W'(H_SYNC_START + SYNC_LAT);
    localparam logic [POS_W-1:0] V_RELOAD  = POS_W'(V_SYNC_START);
    localparam logic [POS_W-1:0] H_VIS     = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_VIS     = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] V_GOOD    = POS_W'(V_TOTAL);
    localparam logic [PER_W:0]   H_GOOD    = (PER_W+1)'(H_TOTAL);
    localparam logic [PER_W-1:0] H_LOST    = PER_W'(2 * H_TOTAL);
    localparam logic [1:0]       LOCK_LAST = 2'(LOCK_FRAMES - 1);

    logic             hs_rise, vs_rise;
    logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d, line_period_q, line_period_d;
    logic [POS_W-1:0] line_cnt_q, line_cnt_d, frame_lines_q, frame_lines_d;
    logic [PER_W:0]   per_sum;
    logic             hgood, vgood, h_fail;
    state_e           state_q, state_d;
    logic [1:0]       good_cnt_q, good_cnt_d;
    logic             sync_err_q, sync_err_d;

    sync_edge_detect u_hs_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_i (hsync_in),
        .rise_o (hs_rise)
    );

    sync_edge_detect u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_i (vsync_in),
        .rise_o (vs_rise)
    );

    // Beam position: free-running raster counters, snapped to the sync edges.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        hpos_d = hpos_q + 1'b1;
        vpos_d = vpos_q;
        if (hpos_q >= H_LAST) begin
            hpos_d = '0;
            vpos_d = (vpos_q >= V_LAST) ? '0 : vpos_q + 1'b1;
        end
        if (hs_rise) hpos_d = H_RELOAD;
        if (vs_rise) vpos_d = V_RELOAD;
    end

    // Measurement: one extra bit on the period sum so a saturated count
    // cannot wrap to a small value and look like a valid line.
    assign per_sum = {1'b0, per_cnt_q} + 1'b1;
    assign hgood   = (per_sum == H_GOOD);
    assign vgood   = (line_cnt_q == V_GOOD);
    assign h_fail  = (hs_rise & ~hgood) | (per_cnt_q == H_LOST);

    always_comb begin
        per_cnt_d     = per_cnt_q;
        line_period_d = line_period_q;
        line_cnt_d    = line_cnt_q;
        frame_lines_d = frame_lines_q;
        if (hs_rise) begin
            per_cnt_d     = '0;
            line_period_d = per_sum[PER_W] ? '1 : per_sum[PER_W-1:0];
        end else if (per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + 1'b1;
        end
        if (vs_rise) begin
            frame_lines_d = line_cnt_q;
            line_cnt_d    = '0;
        end else if (hs_rise && line_cnt_q != '1) begin
            line_cnt_d = line_cnt_q + 1'b1;
        end
    end

    // Lock FSM. A bad line or lost hsync always drops back to SEARCH; only a
    // drop out of LOCKED is reported as sync_err.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        sync_err_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (hs_rise) state_d = ST_H_MEAS;
            end
            ST_H_MEAS: begin
                if (hs_rise && hgood) state_d = ST_V_ALIGN;
            end
            ST_V_ALIGN: begin
                if (h_fail) begin
                    state_d = ST_SEARCH;
                end else if (vs_rise) begin
                    // The partial frame before this edge is never judged.
                    state_d    = ST_V_MEAS;
                    good_cnt_d = '0;
                end
            end
            ST_V_MEAS: begin
                if (h_fail) begin
                    state_d = ST_SEARCH;
                end else if (vs_rise) begin
                    if (!vgood) begin
                        state_d    = ST_V_ALIGN;
                        good_cnt_d = '0;
                    end else if (good_cnt_q == LOCK_LAST) begin
                        state_d = ST_LOCKED;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (h_fail || (vs_rise && !vgood)) begin
                    state_d    = ST_SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            per_cnt_q     <= '0;
            line_period_q <= '0;
            line_cnt_q    <= '0;
            frame_lines_q <= '0;
            state_q       <= ST_SEARCH;
            good_cnt_q    <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            per_cnt_q     <= per_cnt_d;
            line_period_q <= line_period_d;
            line_cnt_q    <= line_cnt_d;
            frame_lines_q <= frame_lines_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign locked      = (state_q == ST_LOCKED);
    assign display_on  = locked && (hpos_q < H_VIS) && (vpos_q < V_VIS);
    assign sync_err    = sync_err_q;
    assign line_period = line_period_q;
    assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_hvsync_decoder.sv
// Bench for hvsync_decoder. A reduced raster (36x20) keeps runs short; the
// generator model registers its syncs exactly like the real sync generator.
module tb_hvsync_decoder;

    localparam int HD = 20, HF = 4, HS = 6, HB = 6;
    localparam int VD = 12, VB = 2, VS = 2, VT = 4;
    localparam int LAT = 2;
    localparam int H_TOTAL = HD + HF + HS + HB;   // 36
    localparam int V_TOTAL = VD + VB + VS + VT;   // 20
    localparam int HSS = HD + HF;                 // 24
    localparam int VSS = VD + VB;                 // 14
    localparam int FRAME = H_TOTAL * V_TOTAL;
    localparam int HOLD_AT = 5;

    logic        clk = 1'b0;
    logic        reset, hsync_in, vsync_in;
    logic [9:0]  hpos, vpos, frame_lines;
    logic [10:0] line_period;
    logic        display_on, locked, sync_err;

    always #5 clk = ~clk;

    hvsync_decoder #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
        .SYNC_LAT(LAT), .LOCK_FRAMES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hpos        (hpos),
        .vpos        (vpos),
        .display_on  (display_on),
        .locked      (locked),
        .sync_err    (sync_err),
        .line_period (line_period),
        .frame_lines (frame_lines)
    );

    typedef struct { int h; int v; bit d; } pos_t;
    typedef enum { SC_GLITCH, SC_SHORT, SC_LOSS } scen_e;
    typedef struct {
        scen_e kind;
        string name;
        bit    ref_vs;     // error latency measured from vsync rise (else hsync rise)
        int    lat;        // samples from that rise to the sync_err sample
        int    lp;         // line_period when sync_err is seen
        int    fl;         // frame_lines when sync_err is seen
        int    relock_vs;  // exact vsync rises until relock, 0 = not checked
    } scen_t;

    pos_t  exp_q[$];
    scen_t scen[3];

    int vec_cnt = 0, miss_cnt = 0;
    int gh = 0, gv = 0;
    bit gen_rst = 1'b1, kill_hs = 1'b0, hold_req = 1'b0, skip_req = 1'b0, chk_pos = 1'b0;
    int since_hs = 0, since_vs = 0, vs_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One pixel clock of the generator model, driven at the falling edge. The
    // expected position is queued as it is driven and checked against what the
    // decoder produced at the preceding rising edge.
    task automatic tick();
        logic hs_n, vs_n;
        pos_t p, e;
        @(negedge clk);
        if (gen_rst) begin
            gh = 0; gv = 0; hs_n = 1'b0; vs_n = 1'b0;
        end else begin
            hs_n = !kill_hs && (gh >= HSS) && (gh < HSS + HS);
            vs_n = (gv >= VSS) && (gv < VSS + VS);
            if (hold_req && gh == HOLD_AT) begin
                hold_req = 1'b0;
            end else if (gh == H_TOTAL - 1) begin
                gh = 0;
                gv = (gv + (skip_req ? 2 : 1)) % V_TOTAL;
                skip_req = 1'b0;
            end else begin
                gh++;
            end
        end
        since_hs = (hs_n && !hsync_in) ? 0 : since_hs + 1;
        if (vs_n && !vsync_in) begin
            since_vs = 0;
            vs_seen++;
        end else begin
            since_vs++;
        end
        hsync_in = hs_n;
        vsync_in = vs_n;
        p.h = gh; p.v = gv; p.d = (gh < HD) && (gv < VD);
        exp_q.push_back(p);
        e = exp_q.pop_front();
        if (chk_pos) begin
            check("pos_locked", locked, 1);
            check("hpos", hpos, e.h);
            check("vpos", vpos, e.v);
            check("display_on", display_on, e.d);
        end
    endtask

    task automatic run_checked(input int n);
        chk_pos = 1'b1;
        repeat (n) tick();
        chk_pos = 1'b0;
    endtask

    task automatic wait_lock(input int exact_vs);
        int n;
        n = 0;
        vs_seen = 0;
        while (!locked && n < 8 * FRAME) begin
            tick();
            n++;
        end
        check("lock_within_bound", locked, 1);
        if (locked && exact_vs > 0) begin
            check("lock_vs_count", vs_seen, exact_vs);
            check("lock_after_vs", since_vs, 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hpos"}, hpos, 0);
        check({tag, "_vpos"}, vpos, 0);
        check({tag, "_display_on"}, display_on, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_sync_err"}, sync_err, 0);
        check({tag, "_line_period"}, line_period, 0);
        check({tag, "_frame_lines"}, frame_lines, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        scen[0] = '{SC_GLITCH, "glitch", 1'b0, 1, H_TOTAL + 1, V_TOTAL, 3};
        scen[1] = '{SC_SHORT,  "short",  1'b1, 1, H_TOTAL, V_TOTAL - 1, 3};
        scen[2] = '{SC_LOSS,   "loss",   1'b0, 2 * H_TOTAL + 2, H_TOTAL, V_TOTAL, 0};

        reset = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        gen_rst = 1'b0;

        // Nominal acquisition: lock one cycle after the third vsync rise.
        wait_lock(3);
        check("nom_line_period", line_period, H_TOTAL);
        check("nom_frame_lines", frame_lines, V_TOTAL);
        run_checked(FRAME);

        for (int i = 0; i < 3; i++) begin
            int n;
            bit seen;
            n = 0;
            seen = 1'b0;
            check({scen[i].name, "_pre_locked"}, locked, 1);
            case (scen[i].kind)
                SC_GLITCH: hold_req = 1'b1;
                SC_SHORT:  skip_req = 1'b1;
                default:   kill_hs  = 1'b1;
            endcase
            while (!seen && n < 2 * FRAME) begin
                tick();
                n++;
                if (sync_err) seen = 1'b1;
            end
            check({scen[i].name, "_err_seen"}, seen, 1);
            if (seen) begin
                check({scen[i].name, "_err_latency"},
                      scen[i].ref_vs ? since_vs : since_hs, scen[i].lat);
                check({scen[i].name, "_line_period"}, line_period, scen[i].lp);
                check({scen[i].name, "_frame_lines"}, frame_lines, scen[i].fl);
                check({scen[i].name, "_unlocked"}, locked, 0);
                tick();
                check({scen[i].name, "_err_one_cycle"}, sync_err, 0);
                check({scen[i].name, "_still_unlocked"}, locked, 0);
            end
            kill_hs = 1'b0;
            wait_lock(scen[i].relock_vs);
            check({scen[i].name, "_relock_period"}, line_period, H_TOTAL);
            check({scen[i].name, "_relock_lines"}, frame_lines, V_TOTAL);
            run_checked(FRAME);
        end

        // Mid-run reset pulse between clock edges; generator keeps running.
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        tick();
        #2 reset = 1'b0;
        wait_lock(3);
        check("midreset_line_period", line_period, H_TOTAL);
        check("midreset_frame_lines", frame_lines, V_TOTAL);
        run_checked(FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
